// File: rtl/alu16_div_seq.sv
// Sequential 16-bit restoring divider that borrows the shared ALU for its trial subtracts.
// Define ALU16_DIV_SIGNED_EN to add the signed_mode port and the sign-fixup state.
module alu16_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
`ifdef ALU16_DIV_SIGNED_EN
  input  logic        signed_mode,
`endif
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_bnegate,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic        alu_carryout
);

  localparam logic [2:0] OP_ADD = 3'b010;

  // state   | meaning
  // S_IDLE  | waiting for operands, start_ready high
  // S_RUN   | one shift/subtract iteration per cycle through the ALU
  // S_FIXUP | apply result signs (signed build only)
  // S_DONE  | result presented until res_ready
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
`ifdef ALU16_DIV_SIGNED_EN
    S_FIXUP = 2'd3,
`endif
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] dreg_q, dreg_d;
  logic [15:0] qreg_q, qreg_d;
  logic [15:0] rem_q, rem_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dbz_q, dbz_d;
  logic        take;
`ifdef ALU16_DIV_SIGNED_EN
  logic        sgn_q, sgn_d;
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dreg_q  <= '0;
      qreg_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef ALU16_DIV_SIGNED_EN
      sgn_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dreg_q  <= dreg_d;
      qreg_q  <= qreg_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
`ifdef ALU16_DIV_SIGNED_EN
      sgn_q   <= sgn_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
`endif
    end
  end

  // rem[15] set means the shifted partial remainder is 17 bits wide, so it always exceeds dreg.
  assign take = rem_q[15] | alu_carryout;

  always_comb begin
    state_d = state_q;
    dreg_d  = dreg_q;
    qreg_d  = qreg_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
`ifdef ALU16_DIV_SIGNED_EN
    sgn_d   = sgn_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          cnt_d  = '0;
          dreg_d = divisor;
          qreg_d = dividend;
          rem_d  = '0;
`ifdef ALU16_DIV_SIGNED_EN
          sgn_d   = signed_mode;
          neg_q_d = signed_mode & (dividend[15] ^ divisor[15]);
          neg_r_d = signed_mode & dividend[15];
          if (signed_mode && divisor[15])  dreg_d = -divisor;
          if (signed_mode && dividend[15]) qreg_d = -dividend;
`endif
          if (divisor == 16'd0) begin
            state_d = S_DONE;
            qreg_d  = 16'hFFFF;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            dbz_d   = 1'b0;
          end
        end
      end
      S_RUN: begin
        rem_d  = take ? alu_result : alu_a;
        qreg_d = {qreg_q[14:0], take};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
`ifdef ALU16_DIV_SIGNED_EN
          state_d = sgn_q ? S_FIXUP : S_DONE;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef ALU16_DIV_SIGNED_EN
      S_FIXUP: begin
        if (neg_q_q) qreg_d = -qreg_q;
        if (neg_r_q) rem_d = -rem_q;
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_ready = (state_q == S_IDLE);
    res_valid   = (state_q == S_DONE);
    quotient    = qreg_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
    alu_a       = {rem_q[14:0], qreg_q[15]};
    alu_b       = dreg_q;
    alu_bnegate = 1'b1;
    alu_op      = OP_ADD;
  end

endmodule

// File: tb/tb_alu16_div_seq.sv
// Scoreboard bench for alu16_div_seq with a behavioural ALU and arithmetic reference model.
module tb_alu16_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
`ifdef ALU16_DIV_SIGNED_EN
  logic        signed_mode = 1'b0;
`endif
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [15:0] quotient, remainder;
  logic        div_by_zero;
  logic [15:0] alu_a, alu_b, alu_result;
  logic        alu_bnegate, alu_carryout;
  logic [2:0]  alu_op;

  alu16_div_seq dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .dividend(dividend), .divisor(divisor),
`ifdef ALU16_DIV_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .res_valid(res_valid), .res_ready(res_ready), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero), .alu_a(alu_a), .alu_b(alu_b),
    .alu_bnegate(alu_bnegate), .alu_op(alu_op), .alu_result(alu_result),
    .alu_carryout(alu_carryout)
  );

  // Shared ripple ALU: A + (BNegate ? ~B : B) + BNegate
  assign {alu_carryout, alu_result} = {1'b0, alu_a}
                                    + {1'b0, (alu_bnegate ? ~alu_b : alu_b)}
                                    + {16'd0, alu_bnegate};

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_iss = 0;
  logic seen = 1'b0;
  logic [15:0] hq, hr;
  logic hd;

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t m;
    int sa, sb_, qi, ri;
    m.acc = 0;
    if (b == 16'd0) begin
      m.q = 16'hFFFF; m.r = a; m.dbz = 1'b1; m.lat = 1;
    end else if (s) begin
      sa = $signed(a); sb_ = $signed(b);
      qi = sa / sb_; ri = sa % sb_;
      m.q = qi[15:0]; m.r = ri[15:0]; m.dbz = 1'b0; m.lat = 18;
    end else begin
      m.q = a / b; m.r = a % b; m.dbz = 1'b0; m.lat = 17;
    end
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Issue side: record expected response at the accept edge
  always @(posedge clk) begin
    exp_t m;
    logic s;
    cyc++;
    if (!rst && start_valid && start_ready) begin
      s = 1'b0;
`ifdef ALU16_DIV_SIGNED_EN
      s = signed_mode;
`endif
      m = model(dividend, divisor, s);
      m.acc = cyc;
      sb.push_back(m);
      n_acc++;
    end
  end

  // Monitor side
  always @(negedge clk) begin
    chk("alu_bnegate", {31'd0, alu_bnegate}, 32'd1);
    chk("alu_op", {29'd0, alu_op}, 32'd2);
    if (rst) begin
      chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
      chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_quotient", {16'd0, quotient}, 32'd0);
      chk("rst_remainder", {16'd0, remainder}, 32'd0);
      chk("rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
      chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
      chk("rst_alu_b", {16'd0, alu_b}, 32'd0);
      seen = 1'b0;
    end else if (res_valid) begin
      if (!seen) begin
        if (sb.size() == 0) begin
          chk("unexpected_res_valid", {31'd0, res_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("quotient", {16'd0, quotient}, {16'd0, e.q});
          chk("remainder", {16'd0, remainder}, {16'd0, e.r});
          chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
          chk("latency", cyc - e.acc + 1, e.lat);
        end
        hq = quotient; hr = remainder; hd = div_by_zero;
        seen = 1'b1;
      end else begin
        chk("hold_quotient", {16'd0, quotient}, {16'd0, hq});
        chk("hold_remainder", {16'd0, remainder}, {16'd0, hr});
        chk("hold_div_by_zero", {31'd0, div_by_zero}, {31'd0, hd});
      end
      chk("start_ready_in_done", {31'd0, start_ready}, 32'd0);
    end else begin
      seen = 1'b0;
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
    int n;
    n = 0;
    while (!start_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL start_ready_timeout actual=0 expected=1");
    end
    dividend = a; divisor = b;
`ifdef ALU16_DIV_SIGNED_EN
    signed_mode = s;
`else
    if (s) $display("note: signed request issued unsigned");
`endif
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    n_iss++;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(sb.size() == 0 && start_ready && !res_valid) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL done_timeout pending=%0d expected=0", sb.size());
    end
  endtask

  task automatic wait_rv();
    int n;
    n = 0;
    while (!res_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL res_valid_timeout actual=0 expected=1");
    end
  endtask

  initial begin
    logic [15:0] a, b;
    logic s;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue(16'd100, 16'd7, 1'b0);          wait_done();
    issue(16'hFFFF, 16'h8001, 1'b0);      wait_done();
    issue(16'hFFFF, 16'd1, 1'b0);         wait_done();
    issue(16'd1234, 16'd0, 1'b0);         wait_done();
    issue(16'd1000, 16'd10, 1'b0);        wait_done();

    // Result held in DONE while a second request waits
    res_ready = 1'b0;
    issue(16'd500, 16'd3, 1'b0);
    wait_rv();
    dividend = 16'd9; divisor = 16'd4; start_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    n_iss++;
    wait_done();

    // Abort mid-RUN
    issue(16'd60000, 16'd7, 1'b0);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    issue(16'd50, 16'd5, 1'b0);           wait_done();

`ifdef ALU16_DIV_SIGNED_EN
    issue(16'hFFF9, 16'd2, 1'b1);         wait_done();
    issue(16'h8000, 16'hFFFF, 1'b1);      wait_done();
    issue(16'hFF00, 16'd0, 1'b1);         wait_done();
`endif

    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 16'd0;
        1: b = 16'($urandom_range(1, 15));
        2: b = 16'($urandom);
        default: b = 16'($urandom) | 16'h8000;
      endcase
`ifdef ALU16_DIV_SIGNED_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      issue(a, b, s);
      if ($urandom_range(0, 3) == 0) begin
        res_ready = 1'b0;
        wait_rv();
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 res_ready = 1'b1;
      end
      wait_done();
    end

    chk("accept_count", n_acc, n_iss);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu16_div_seq.md
# alu16_div_seq

Multi-cycle 16-bit restoring divider that drives the shared 16-bit ALU from the operand side: it issues one subtract per cycle on the ALU's A/B/BNegate/Op inputs and consumes Result and CarryOut to build quotient and remainder. It sits between the execute-stage issue logic and the ALU instance, so DIV/MOD instructions reuse the existing ripple adder instead of a dedicated subtractor. Operands arrive and results leave over valid/ready handshakes.

## Interface
- OP_ADD, 3'b010, ALU Op encoding for add/subtract; driven constantly on alu_op
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start_valid  input  1  operands valid
- start_ready  output  1  divider idle, can accept
- dividend  input  16  numerator
- divisor  input  16  denominator
- signed_mode  input  1  signed division (present only with ALU16_DIV_SIGNED_EN)
- res_valid  output  1  result valid, held until accepted
- res_ready  input  1  consumer accepts result
- quotient  output  16  quotient
- remainder  output  16  remainder
- div_by_zero  output  1  divisor was zero
- alu_a  output  16  ALU A operand
- alu_b  output  16  ALU B operand
- alu_bnegate  output  1  ALU BNegate; constant 1 (subtract, carry-in 1)
- alu_op  output  3  ALU Op; constant OP_ADD
- alu_result  input  16  ALU Result
- alu_carryout  input  1  ALU CarryOut (1 = no borrow, unsigned A >= B)

## Operation
- States: IDLE, RUN, FIXUP (signed build only), DONE.
- IDLE: start_ready=1. On start_valid: latch divisor into dreg, dividend into qreg, rem=0, msb=0, count=0.
  - divisor==0 -> DONE directly; quotient=16'hFFFF, remainder=dividend, div_by_zero=1.
  - else -> RUN, div_by_zero=0.
- RUN, each cycle: alu_a={rem[14:0],qreg[15]}, alu_b=dreg (combinational from registers). take = rem[15] | alu_carryout. If take: rem<=alu_result, qreg<={qreg[14:0],1}; else rem<=alu_a, qreg<={qreg[14:0],0}. count increments; after 16th iteration (count==15) -> DONE (or FIXUP if signed).
  - rem[15] term covers the 17-bit partial remainder case; 16-bit wrapped alu_result is then correct.
- DONE: res_valid=1, quotient=qreg, remainder=rem, stable while res_ready=0. res_valid & res_ready -> IDLE.
- start_valid outside IDLE ignored (start_ready=0); no queueing.
- Outside RUN, alu_a/alu_b still track registers; ALU outputs are don't-care.

## Timing
- Reset (async, immediate): state=IDLE, start_ready=1, res_valid=0, quotient=0, remainder=0, div_by_zero=0, alu_a=0, alu_b=0; alu_bnegate=1, alu_op=OP_ADD always.
- Accept edge = cycle 0. Unsigned: RUN cycles 1–16, res_valid high from cycle 17. Signed: +1 cycle (18). Divide-by-zero: res_valid from cycle 1.
- Back-to-back: earliest next accept is the cycle after the res_valid&res_ready edge (start_ready rises then).
- rst asserted mid-RUN/DONE: abort, discard result, outputs to reset values; no res_valid for the aborted operation.
- ALU path is combinational in one cycle: alu_a -> ALU -> alu_result/alu_carryout -> rem register.

## Configuration
- ALU16_DIV_SIGNED_EN defined: signed_mode port present. Signed accept latches |dividend|, |divisor| and sign flags; RUN unchanged; FIXUP negates quotient if sign(dividend)^sign(divisor), remainder if sign(dividend). -32768 / -1 -> quotient 16'h8000, remainder 0 (wraps). Divide-by-zero: quotient 16'hFFFF, remainder=dividend, no FIXUP.
- Undefined: no signed_mode port, no FIXUP state; unsigned only, 17-cycle latency.

## Test plan
- 100 / 7 unsigned -> quotient 14, remainder 2, res_valid exactly cycle 17 after accept.
- 16'hFFFF / 16'h8001 (exercises rem[15] path) -> quotient 1, remainder 16'h7FFE; 16'hFFFF / 1 -> quotient 16'hFFFF, remainder 0.
- 1234 / 0 -> div_by_zero=1, quotient 16'hFFFF, remainder 1234, res_valid at cycle 1; next divide has div_by_zero=0.
- Hold res_ready=0 for 10 cycles in DONE with start_valid=1 -> results stable, start_ready=0, second request accepted only after handshake.
- rst pulse at RUN cycle 8 -> all outputs reset values immediately; following 50 / 5 -> quotient 10, remainder 0.
- ALU16_DIV_SIGNED_EN: -7 / 2 -> quotient -3 (16'hFFFD), remainder -1 (16'hFFFF), latency 18; -32768 / -1 -> 16'h8000, 0.
